// File: rtl/audio_fetch_ctrl.sv
// Audio sample fetch controller.
// Streams 16-bit sample words from a word-addressed memory bridge into a small
// FIFO and hands them to the serializer, one per smp_req pulse. Supports one-shot
// and looped playback, pause, abort and retry of reads that are never acknowledged.
module audio_fetch_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_pause,
  input  logic        loop_en,
  input  logic [24:0] addr_start,
  input  logic [24:0] addr_end,
  output logic [24:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rddata,
  input  logic        mem_ack,
  input  logic        smp_req,
  output logic [15:0] smp_data,
  output logic        smp_valid,
  output logic        playing,
  output logic        done,
  output logic [7:0]  underflow_cnt,
  output logic [24:0] cur_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST_C = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  state_t        ret_q, ret_d;            // state to resume when pause is released
  logic [24:0]   start_q, start_d;
  logic [24:0]   end_q, end_d;
  logic [24:0]   fetch_q, fetch_d;
  logic          rd_q, rd_d;              // read outstanding == mem_rd
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   fifo_q [FIFO_DEPTH];
  logic [15:0]   smp_data_q, smp_data_d;
  logic          smp_valid_q, smp_valid_d;
  logic          playing_q, playing_d;
  logic          done_q, done_d;
  logic [7:0]    under_q, under_d;

  logic hs_s;       // read handshake this cycle
  logic last_s;     // current fetch address is the final word of the range
  logic flush_s;    // empty the FIFO and cancel any read
  logic push_s;
  logic pop_s;

  assign hs_s   = rd_q & mem_ack;
  assign last_s = (fetch_q == end_q);

  // Playback state machine and fetch address sequencing.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    start_d = start_q;
    end_d   = end_q;
    fetch_d = fetch_q;
    flush_s = 1'b0;
    push_s  = 1'b0;
    if (cmd_stop) begin
      state_d = ST_IDLE;
      flush_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cmd_start) begin
            start_d = addr_start;
            end_d   = addr_end;
            fetch_d = addr_start;
            flush_s = 1'b1;
            ret_d   = ST_REQ;
            if (addr_end < addr_start) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_REQ;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_REQ: begin
          if (hs_s) begin
            push_s = 1'b1;
            if (!last_s) begin
              fetch_d = fetch_q + 25'd1;
            end else if (loop_en) begin
              fetch_d = start_q;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            fetch_d = fetch_q;
          end
          if (cmd_pause) begin
            ret_d   = state_d;
            state_d = ST_PAUSE;
          end else begin
            ret_d = ret_q;
          end
        end
        ST_PAUSE: begin
          // A read issued before the pause may still land here.
          if (hs_s) begin
            push_s = 1'b1;
            if (!last_s) begin
              fetch_d = fetch_q + 25'd1;
            end else if (loop_en) begin
              fetch_d = start_q;
            end else begin
              ret_d = ST_DRAIN;
            end
          end else begin
            fetch_d = fetch_q;
          end
          if (!cmd_pause) begin
            state_d = ret_d;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DRAIN: begin
          if (cmd_pause) begin
            ret_d   = ST_DRAIN;
            state_d = ST_PAUSE;
          end else if (count_q == {CW{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Read request: one outstanding read, dropped on ack or timeout, issued only in REQ with room.
  always_comb begin
    rd_d  = rd_q;
    tmo_d = tmo_q;
    if (flush_s) begin
      rd_d  = 1'b0;
      tmo_d = {TW{1'b0}};
    end else if (rd_q) begin
      if (mem_ack || (tmo_q == TMO_LAST_C)) begin
        rd_d  = 1'b0;
        tmo_d = {TW{1'b0}};
      end else begin
        rd_d  = 1'b1;
        tmo_d = tmo_q + TW'(1);
      end
    end else if ((state_q == ST_REQ) && (state_d == ST_REQ) && (count_q < DEPTH_C)) begin
      rd_d  = 1'b1;
      tmo_d = {TW{1'b0}};
    end else begin
      rd_d  = 1'b0;
      tmo_d = {TW{1'b0}};
    end
  end

  // FIFO pointers, sample response, starvation counter and status flags.
  always_comb begin
    pop_s       = smp_req & ~flush_s & (count_q != {CW{1'b0}}) & (state_q != ST_PAUSE);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    under_d     = under_q;
    smp_valid_d = smp_req;
    smp_data_d  = 16'h0000;
    if (pop_s) begin
      smp_data_d = fifo_q[rd_ptr_q];
    end else begin
      smp_data_d = 16'h0000;
    end
    if (flush_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    if (smp_req && !flush_s && (count_q == {CW{1'b0}}) && (state_q == ST_REQ) && (under_q != 8'hFF)) begin
      under_d = under_q + 8'd1;
    end else begin
      under_d = under_q;
    end
    playing_d = (state_d == ST_REQ) || (state_d == ST_PAUSE) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
  end

  // State and control registers.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_REQ;
      start_q     <= 25'd0;
      end_q       <= 25'd0;
      fetch_q     <= 25'd0;
      rd_q        <= 1'b0;
      tmo_q       <= {TW{1'b0}};
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      smp_data_q  <= 16'h0000;
      smp_valid_q <= 1'b0;
      playing_q   <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      start_q     <= start_d;
      end_q       <= end_d;
      fetch_q     <= fetch_d;
      rd_q        <= rd_d;
      tmo_q       <= tmo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      smp_data_q  <= smp_data_d;
      smp_valid_q <= smp_valid_d;
      playing_q   <= playing_d;
      done_q      <= done_d;
      under_q     <= under_d;
    end
  end

  // FIFO storage: write the acknowledged word at the write pointer.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 16'h0000;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= mem_rddata;
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  assign mem_addr      = fetch_q;
  assign cur_addr      = fetch_q;
  assign mem_rd        = rd_q;
  assign smp_data      = smp_data_q;
  assign smp_valid     = smp_valid_q;
  assign playing       = playing_q;
  assign done          = done_q;
  assign underflow_cnt = under_q;

endmodule

// File: tb/tb_audio_fetch_ctrl.sv
// Self-checking bench for audio_fetch_ctrl: memory responder model, FIFO
// mirror and sample scoreboard, one task per scenario.
module tb_audio_fetch_ctrl;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_pause, loop_en;
  logic [24:0] addr_start, addr_end;
  logic [24:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rddata;
  logic        mem_ack;
  logic        smp_req;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        playing, done;
  logic [7:0]  underflow_cnt;
  logic [24:0] cur_addr;

  audio_fetch_ctrl dut (
    .clk50(clk50), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_pause(cmd_pause), .loop_en(loop_en), .addr_start(addr_start), .addr_end(addr_end),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rddata(mem_rddata), .mem_ack(mem_ack),
    .smp_req(smp_req), .smp_data(smp_data), .smp_valid(smp_valid), .playing(playing),
    .done(done), .underflow_cnt(underflow_cnt), .cur_addr(cur_addr)
  );

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  int err = 0;
  int chk = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } sb_t;

  sb_t         sb_q[$];      // expected sample responses
  logic [15:0] exp_q[$];     // mirror of the DUT FIFO contents
  logic [24:0] rd_log[$];    // acknowledged read addresses
  int          rd_starts = 0;
  bit          prev_rd = 1'b0;
  bit          resp_en = 1'b0;
  int          resp_lat = 1;
  int          wcnt = 0;
  bit          ack_pend = 1'b0;
  logic [24:0] ack_addr;
  sb_t         mon_e;

  function automatic logic [15:0] mdata(input logic [24:0] a);
    return a[15:0] ^ 16'hB7E1;
  endfunction

  // Advance one cycle and run the memory responder model.
  task automatic tick();
    @(posedge clk50);
    #1;
    if (ack_pend) begin
      exp_q.push_back(mdata(ack_addr));
      rd_log.push_back(ack_addr);
      ack_pend = 1'b0;
    end
    if (mem_rd === 1'b1 && !prev_rd) rd_starts++;
    prev_rd = (mem_rd === 1'b1);
    mem_ack = 1'b0;
    if (resp_en && mem_rd === 1'b1) begin
      wcnt++;
      if (wcnt >= resp_lat) begin
        mem_ack    = 1'b1;
        mem_rddata = mdata(mem_addr);
        ack_addr   = mem_addr;
        ack_pend   = 1'b1;
        wcnt       = 0;
      end
    end else begin
      wcnt = 0;
    end
  endtask

  // Pulse smp_req and queue the expected response.
  task automatic smp_pulse(input bit expect_zero);
    sb_t e;
    e.due = cyc + 1;
    if (expect_zero || exp_q.size() == 0) e.data = 16'h0000;
    else e.data = exp_q.pop_front();
    sb_q.push_back(e);
    smp_req = 1'b1;
    tick();
    smp_req = 1'b0;
  endtask

  task automatic start_play(input logic [24:0] s, input logic [24:0] e, input bit lp);
    rd_log.delete();
    exp_q.delete();
    rd_starts  = 0;
    addr_start = s;
    addr_end   = e;
    loop_en    = lp;
    cmd_start  = 1'b1;
    tick();
    cmd_start  = 1'b0;
  endtask

  task automatic stop_clean();
    cmd_stop = 1'b1;
    tick();
    cmd_stop = 1'b0;
    exp_q.delete();
    ack_pend = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: compare every smp_valid against the queued expectation.
  always @(negedge clk50) begin
    if (smp_valid === 1'b1) begin
      chk++;
      if (sb_q.size() == 0) begin
        err++;
        $display("FAIL smp_unexpected: smp_valid=1 data=%h at cycle %0d, no request pending", smp_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.due != cyc || smp_data !== mon_e.data) begin
          err++;
          $display("FAIL smp_data: got %h at cycle %0d, expected %h at cycle %0d", smp_data, cyc, mon_e.data, mon_e.due);
        end
      end
    end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      chk++;
      err++;
      $display("FAIL smp_valid_missing: smp_valid=%b at cycle %0d, expected 1", smp_valid, cyc);
      sb_q.delete(0);
    end
  end

  task automatic test_reset();
    repeat (3) tick();
    chk++;
    if ({mem_rd, smp_valid, playing, done} !== 4'b0000) begin
      err++; $display("FAIL reset_flags: {rd,valid,playing,done}=%b expected 0000", {mem_rd, smp_valid, playing, done});
    end
    chk++;
    if (mem_addr !== 25'd0 || cur_addr !== 25'd0) begin
      err++; $display("FAIL reset_addr: mem_addr=%h cur_addr=%h expected 0", mem_addr, cur_addr);
    end
    chk++;
    if (smp_data !== 16'h0000 || underflow_cnt !== 8'd0) begin
      err++; $display("FAIL reset_data: smp_data=%h underflow=%0d expected 0", smp_data, underflow_cnt);
    end
    reset = 1'b0;
    tick();
    smp_pulse(1'b0);
    tick();
    chk++;
    if (underflow_cnt !== 8'd0) begin
      err++; $display("FAIL idle_no_underflow: underflow=%0d expected 0", underflow_cnt);
    end
  endtask

  task automatic test_single_pass();
    resp_en  = 1'b1;
    resp_lat = 3;
    start_play(25'h09E, 25'h0A1, 1'b0);
    chk++;
    if (playing !== 1'b1 || done !== 1'b0) begin
      err++; $display("FAIL single_start: playing=%b done=%b expected 1 0", playing, done);
    end
    for (int i = 0; i < 200 && rd_log.size() < 4; i++) tick();
    repeat (5) tick();
    chk++;
    if (rd_log.size() != 4 || rd_starts != 4) begin
      err++; $display("FAIL single_reads: acked=%0d issued=%0d expected 4 4", rd_log.size(), rd_starts);
    end
    for (int k = 0; k < 4; k++) begin
      chk++;
      if (k >= rd_log.size() || rd_log[k] !== 25'h09E + 25'(k)) begin
        err++; $display("FAIL single_addr%0d: got %h expected %h", k, (k < rd_log.size()) ? rd_log[k] : 25'h1FFFFFF, 25'h09E + 25'(k));
      end
    end
    chk++;
    if (playing !== 1'b1 || done !== 1'b0 || cur_addr !== 25'h0A1) begin
      err++; $display("FAIL single_drain: playing=%b done=%b cur_addr=%h expected 1 0 0a1", playing, done, cur_addr);
    end
    repeat (4) smp_pulse(1'b0);
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
    chk++;
    if (done !== 1'b1 || playing !== 1'b0 || rd_starts != 4) begin
      err++; $display("FAIL single_done: done=%b playing=%b issued=%0d expected 1 0 4", done, playing, rd_starts);
    end
    stop_clean();
  endtask

  task automatic test_loop();
    bit done_seen = 1'b0;
    resp_lat = 1;
    start_play(25'h010, 25'h011, 1'b1);
    repeat (10) tick();
    for (int i = 0; i < 30; i++) begin
      smp_pulse(1'b0);
      done_seen |= (done === 1'b1);
      tick();
      done_seen |= (done === 1'b1);
      tick();
      done_seen |= (done === 1'b1);
    end
    chk++;
    if (done_seen || rd_log.size() < 12) begin
      err++; $display("FAIL loop_run: done_seen=%b reads=%0d expected 0 and >=12", done_seen, rd_log.size());
    end
    for (int k = 0; k < rd_log.size(); k++) begin
      chk++;
      if (rd_log[k] !== ((k % 2 == 1) ? 25'h011 : 25'h010)) begin
        err++; $display("FAIL loop_addr%0d: got %h expected %h", k, rd_log[k], (k % 2 == 1) ? 25'h011 : 25'h010);
      end
    end
    stop_clean();
  endtask

  task automatic test_full_hold();
    resp_lat = 2;
    start_play(25'h100, 25'h1FF, 1'b0);
    for (int i = 0; i < 100 && rd_log.size() < 4; i++) tick();
    repeat (20) tick();
    chk++;
    if (rd_starts != 4 || mem_rd !== 1'b0) begin
      err++; $display("FAIL full_hold: issued=%0d mem_rd=%b expected 4 0", rd_starts, mem_rd);
    end
    smp_pulse(1'b0);
    repeat (20) tick();
    chk++;
    if (rd_starts != 5 || rd_log.size() != 5 || rd_log[rd_log.size()-1] !== 25'h104) begin
      err++; $display("FAIL full_refill: issued=%0d acked=%0d expected 5 5 ending at 104", rd_starts, rd_log.size());
    end
    stop_clean();
    smp_pulse(1'b0);   // FIFO must have been flushed by the stop
    tick();
  endtask

  task automatic test_pause();
    int snap;
    resp_lat = 1;
    start_play(25'h600, 25'h6FF, 1'b0);
    repeat (15) tick();
    smp_pulse(1'b0);
    cmd_pause = 1'b1;
    snap = rd_starts;
    tick();
    chk++;
    if (playing !== 1'b1 || done !== 1'b0) begin
      err++; $display("FAIL pause_state: playing=%b done=%b expected 1 0", playing, done);
    end
    smp_pulse(1'b1);
    repeat (5) tick();
    chk++;
    if (rd_starts != snap || mem_rd !== 1'b0) begin
      err++; $display("FAIL pause_noread: issued=%0d mem_rd=%b expected %0d 0", rd_starts, mem_rd, snap);
    end
    cmd_pause = 1'b0;
    repeat (6) tick();
    chk++;
    if (rd_starts != snap + 1) begin
      err++; $display("FAIL pause_resume: issued=%0d expected %0d", rd_starts, snap + 1);
    end
    smp_pulse(1'b0);
    stop_clean();
  endtask

  task automatic test_timeout();
    int  hi = 0;
    bit  addr_ok = 1'b1;
    resp_en = 1'b0;
    start_play(25'h200, 25'h20F, 1'b0);
    for (int i = 0; i < 20 && mem_rd !== 1'b1; i++) tick();
    chk++;
    if (mem_rd !== 1'b1) begin
      err++; $display("FAIL tmo_issue: mem_rd=%b expected 1", mem_rd);
    end
    while (mem_rd === 1'b1 && hi < 200) begin
      if (mem_addr !== 25'h200) addr_ok = 1'b0;
      hi++;
      tick();
    end
    chk++;
    if (hi != 64 || !addr_ok) begin
      err++; $display("FAIL tmo_len: high for %0d cycles addr_stable=%b expected 64 1", hi, addr_ok);
    end
    tick();
    chk++;
    if (mem_rd !== 1'b1 || mem_addr !== 25'h200) begin
      err++; $display("FAIL tmo_retry: mem_rd=%b mem_addr=%h expected 1 200", mem_rd, mem_addr);
    end
    stop_clean();
  endtask

  task automatic test_underflow();
    resp_en = 1'b0;
    start_play(25'h300, 25'h3FF, 1'b0);
    repeat (3) tick();
    for (int i = 0; i < 100; i++) smp_pulse(1'b0);
    chk++;
    if (underflow_cnt !== 8'd100) begin
      err++; $display("FAIL underflow_100: got %0d expected 100", underflow_cnt);
    end
    for (int i = 0; i < 200; i++) smp_pulse(1'b0);
    chk++;
    if (underflow_cnt !== 8'd255) begin
      err++; $display("FAIL underflow_sat: got %0d expected 255", underflow_cnt);
    end
    stop_clean();
  endtask

  task automatic test_stop();
    resp_en = 1'b0;
    start_play(25'h400, 25'h40F, 1'b0);
    for (int i = 0; i < 20 && mem_rd !== 1'b1; i++) tick();
    cmd_stop = 1'b1;
    tick();
    cmd_stop   = 1'b0;
    mem_ack    = 1'b1;
    mem_rddata = 16'hDEAD;
    chk++;
    if (mem_rd !== 1'b0 || playing !== 1'b0) begin
      err++; $display("FAIL stop_now: mem_rd=%b playing=%b expected 0 0", mem_rd, playing);
    end
    repeat (6) tick();
    chk++;
    if (mem_rd !== 1'b0 || rd_starts != 1) begin
      err++; $display("FAIL stop_idle: mem_rd=%b issued=%0d expected 0 1", mem_rd, rd_starts);
    end
    smp_pulse(1'b0);
    // start and stop together: stop wins
    addr_start = 25'h500;
    addr_end   = 25'h50F;
    cmd_start  = 1'b1;
    cmd_stop   = 1'b1;
    tick();
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    repeat (3) tick();
    chk++;
    if (playing !== 1'b0 || done !== 1'b0 || mem_rd !== 1'b0) begin
      err++; $display("FAIL start_stop: playing=%b done=%b mem_rd=%b expected 0 0 0", playing, done, mem_rd);
    end
    // inverted range goes straight to DONE
    start_play(25'h050, 25'h040, 1'b0);
    tick();
    chk++;
    if (done !== 1'b1 || playing !== 1'b0 || mem_rd !== 1'b0) begin
      err++; $display("FAIL bad_range: done=%b playing=%b mem_rd=%b expected 1 0 0", done, playing, mem_rd);
    end
    // start from DONE, then reset in the middle of a read
    start_play(25'h700, 25'h70F, 1'b0);
    chk++;
    if (playing !== 1'b1 || done !== 1'b0) begin
      err++; $display("FAIL done_restart: playing=%b done=%b expected 1 0", playing, done);
    end
    for (int i = 0; i < 20 && mem_rd !== 1'b1; i++) tick();
    reset = 1'b1;
    #1;
    chk++;
    if (mem_rd !== 1'b0 || playing !== 1'b0 || underflow_cnt !== 8'd0) begin
      err++; $display("FAIL reset_async: mem_rd=%b playing=%b underflow=%0d expected 0 0 0", mem_rd, playing, underflow_cnt);
    end
    tick();
    reset      = 1'b0;
    mem_ack    = 1'b1;
    mem_rddata = 16'hBEEF;
    tick();
    chk++;
    if (mem_rd !== 1'b0 || playing !== 1'b0) begin
      err++; $display("FAIL reset_late_ack: mem_rd=%b playing=%b expected 0 0", mem_rd, playing);
    end
    smp_pulse(1'b0);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_start  = 1'b0;
    cmd_stop   = 1'b0;
    cmd_pause  = 1'b0;
    loop_en    = 1'b0;
    addr_start = 25'd0;
    addr_end   = 25'd0;
    mem_rddata = 16'h0000;
    mem_ack    = 1'b0;
    smp_req    = 1'b0;
    test_reset();
    test_single_pass();
    test_loop();
    test_full_hold();
    test_pause();
    test_timeout();
    test_underflow();
    test_stop();
    repeat (4) tick();
    chk++;
    if (sb_q.size() != 0) begin
      err++; $display("FAIL sb_drain: %0d sample responses outstanding, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/audio_fetch_ctrl.md
AUDIO_FETCH_CTRL -- requirements
Module: audio_fetch_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of 16-bit sample entries buffered (power of two, 2..16).
REQ-002 Parameter ACK_TIMEOUT, default 64, SHALL set the clk50 cycles a read may wait for mem_ack before it is retried.
REQ-003 clk50  in  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_start  in  1  one-cycle pulse: begin playback at addr_start.
REQ-006 cmd_stop  in  1  one-cycle pulse: abort playback and return to IDLE.
REQ-007 cmd_pause  in  1  level: hold playback while high.
REQ-008 loop_en  in  1  level: wrap from addr_end back to addr_start.
REQ-009 addr_start  in  25  first sample word address, sampled on cmd_start.
REQ-010 addr_end  in  25  last sample word address (inclusive), sampled on cmd_start.
REQ-011 mem_addr  out  25  read word address (one address per 16-bit word).
REQ-012 mem_rd  out  1  read request; held high until mem_ack.
REQ-013 mem_rddata  in  16  read data, valid in the cycle mem_ack is high.
REQ-014 mem_ack  in  1  read acknowledge from the memory bridge.
REQ-015 smp_req  in  1  one-cycle pulse from the serializer (already synchronised to clk50) requesting the next sample.
REQ-016 smp_data  out  16  sample returned for the last smp_req.
REQ-017 smp_valid  out  1  one-cycle pulse; smp_data is valid.
REQ-018 playing  out  1  high in the REQ, PAUSE and DRAIN states.
REQ-019 done  out  1  high in the DONE state.
REQ-020 underflow_cnt  out  8  saturating count of starved requests.
REQ-021 cur_addr  out  25  current fetch address, for the hex display.

Function
REQ-022 FSM states SHALL be IDLE, REQ, PAUSE, DRAIN and DONE; registered outputs SHALL change on the clock edge following the causing input.
REQ-023 IDLE: cmd_start SHALL latch both addresses, set fetch_addr = addr_start, flush the FIFO and go to REQ; if addr_end < addr_start, it SHALL go to DONE instead.
REQ-024 REQ: mem_rd SHALL assert only when the FIFO count < FIFO_DEPTH and no read is outstanding; at most one read SHALL be outstanding at any time.
REQ-025 mem_addr SHALL equal fetch_addr and SHALL remain stable while mem_rd is high.
REQ-026 A cycle with mem_rd=1 and mem_ack=1 SHALL push mem_rddata into the FIFO and drop mem_rd for at least one cycle.
REQ-027 In that same handshake cycle, fetch_addr SHALL increment by 1.
REQ-028 Exception to REQ-027: if fetch_addr == addr_end, fetch_addr SHALL reload addr_start when loop_en=1; otherwise the FSM SHALL go to DRAIN.
REQ-029 mem_ack arriving while mem_rd=0 SHALL be ignored.
REQ-030 If mem_rd stays high ACK_TIMEOUT cycles without mem_ack, mem_rd SHALL drop for one cycle and then reassert at the same address.
REQ-031 cmd_pause=1 in REQ or DRAIN SHALL move the FSM to PAUSE.
REQ-032 An outstanding read SHALL still complete and push its data in PAUSE; no new read SHALL start in PAUSE.
REQ-033 Deasserting cmd_pause SHALL return the FSM to the state it was in before PAUSE.
REQ-034 DRAIN: no reads SHALL be issued; when the FIFO is empty, the FSM SHALL go to DONE.
REQ-035 DONE: done=1; cmd_start SHALL behave as in IDLE.
REQ-036 cmd_stop in any state SHALL force IDLE, mem_rd=0 and an empty FIFO next cycle; any late mem_ack SHALL be ignored.
REQ-037 cmd_stop and cmd_start in the same cycle: stop SHALL win.
REQ-038 smp_req SHALL produce smp_valid exactly 1 cycle later.
REQ-039 For that smp_req, smp_data SHALL be the FIFO head, which is popped, if the FIFO is non-empty and the state is not PAUSE; otherwise smp_data SHALL be 16'h0000 and the FIFO is untouched.
REQ-040 An empty-FIFO smp_req in REQ SHALL increment underflow_cnt, saturating at 255; starved requests in IDLE, PAUSE, DRAIN and DONE SHALL NOT count.
REQ-041 A push and a pop in the same cycle SHALL both occur, leaving the count unchanged; the FIFO SHALL preserve word order across its pointer wrap.
REQ-042 cur_addr SHALL equal fetch_addr.

Reset
REQ-043 reset SHALL force state IDLE, FIFO count 0, pointers 0, mem_rd=0, mem_addr=0, cur_addr=0, smp_data=0, smp_valid=0, playing=0, done=0 and underflow_cnt=0.
REQ-044 Reset mid-read SHALL drop mem_rd immediately, and the next mem_ack SHALL be ignored.

Verification
REQ-045 Start 0x09E..0x0A1, loop_en=0, ack 3 cycles after mem_rd -> four reads at 0x09E-0x0A1; four smp_req return those words in order; DRAIN then done=1.
REQ-046 loop_en=1, range 0x10..0x11, ack every read -> mem_addr sequence 10,11,10,11,...; done never asserts.
REQ-047 Fill the FIFO to 4, no smp_req -> mem_rd stays 0; one smp_req -> exactly one new read.
REQ-048 Hold mem_ack=0 for 64 cycles -> mem_rd drops for 1 cycle and re-requests the same address.
REQ-049 Empty FIFO in REQ, 300 smp_req -> smp_data=0 each time; underflow_cnt saturates at 255.
REQ-050 cmd_stop with mem_rd high, ack arriving the next cycle -> IDLE, FIFO empty, the ack ignored; cmd_start+cmd_stop together -> stays IDLE.
